ex_alu_stage: RTL and testbench

Execute stage of the pipelined RISC-V core. It sits directly downstream of the ALU controller and consumes its 4-bit `Operation` code together with the two operands from the ID/EX path. It computes the result and registers it into a 2-entry output buffer (main + skid) with valid/ready handshakes on both sides. It then presents the result, zero flag and writeback tags to the MEM stage.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_core.sv | 41 ++++
 rtl/ex_alu_stage.sv | 127 ++++++++++++
 tb/tb_ex_alu_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execute-stage bundle types.
// Used by the ALU controller, execute stage and forwarding logic.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam int RD_W = 5;

  // Per-entry side information travelling with a result.
  typedef struct packed {
    logic            zero;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            illegal;
  } ex_tag_t;

  function automatic logic alu_op_legal(
    input logic [3:0] op
  );
    logic ok;
    ok = 1'b0;
    unique case (op)
      ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLT, ALU_ADD, ALU_SUB: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: operation code and operands to result.
// Unknown codes yield a zero result and raise illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  // Select the result for the requested operation.
  always_comb begin
    result  = '0;
    illegal = ~alu_op_legal(operation);
    unique case (operation)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_alu_stage.sv
// Execute stage: ALU plus a main/skid output buffer.
// in_ready depends only on registered state.
module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_operation,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_regwrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_regwrite,
  output logic             out_illegal
);

  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_illegal;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .operation(in_operation),
    .a        (in_a),
    .b        (in_b),
    .result   (alu_result),
    .zero     (alu_zero),
    .illegal  (alu_illegal)
  );

  ex_tag_t new_tag;

  // Bundle the tags; illegal ops never write back.
  always_comb begin
    new_tag          = '0;
    new_tag.zero     = alu_zero;
    new_tag.rd       = in_rd;
    new_tag.regwrite = in_regwrite & ~alu_illegal;
    new_tag.illegal  = alu_illegal;
  end

  logic             main_valid_q;
  logic             main_valid_d;
  logic             skid_valid_q;
  logic             skid_valid_d;
  logic [WIDTH-1:0] main_result_q;
  logic [WIDTH-1:0] main_result_d;
  logic [WIDTH-1:0] skid_result_q;
  logic [WIDTH-1:0] skid_result_d;
  ex_tag_t          main_tag_q;
  ex_tag_t          main_tag_d;
  ex_tag_t          skid_tag_q;
  ex_tag_t          skid_tag_d;

  logic in_fire;

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready & ~flush;

  // Buffer steering: fill main, spill to skid, drain skid.
  always_comb begin
    main_valid_d  = main_valid_q;
    skid_valid_d  = skid_valid_q;
    main_result_d = main_result_q;
    skid_result_d = skid_result_q;
    main_tag_d    = main_tag_q;
    skid_tag_d    = skid_tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (out_ready) begin
        main_result_d = skid_result_q;
        main_tag_d    = skid_tag_q;
        skid_valid_d  = 1'b0;
      end
    end else if (!main_valid_q || out_ready) begin
      main_valid_d = in_fire;
      if (in_fire) begin
        main_result_d = alu_result;
        main_tag_d    = new_tag;
      end
    end else if (in_fire) begin
      skid_valid_d  = 1'b1;
      skid_result_d = alu_result;
      skid_tag_d    = new_tag;
    end
  end

  // Buffer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q  <= 1'b0;
      skid_valid_q  <= 1'b0;
      main_result_q <= '0;
      skid_result_q <= '0;
      main_tag_q    <= '0;
      skid_tag_q    <= '0;
    end else begin
      main_valid_q  <= main_valid_d;
      skid_valid_q  <= skid_valid_d;
      main_result_q <= main_result_d;
      skid_result_q <= skid_result_d;
      main_tag_q    <= main_tag_d;
      skid_tag_q    <= skid_tag_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_result   = main_result_q;
  assign out_zero     = main_tag_q.zero;
  assign out_rd       = main_tag_q.rd;
  assign out_regwrite = main_tag_q.regwrite;
  assign out_illegal  = main_tag_q.illegal;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Scoreboard bench for ex_alu_stage.
// Directed scenarios followed by randomized traffic.
module tb_ex_alu_stage;

  localparam int W = 32;

  typedef logic [W+7:0] ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_operation = 4'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [4:0]   in_rd = 5'd0;
  logic         in_regwrite = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic [4:0]   out_rd;
  logic         out_regwrite;
  logic         out_illegal;

  ex_alu_stage #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_operation(in_operation),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_rd       (in_rd),
    .in_regwrite (in_regwrite),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_rd      (out_rd),
    .out_regwrite(out_regwrite),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  ent_t exp_q[$];
  logic hold_inputs = 1'b0;

  // Reference: plain arithmetic from the operation table.
  function automatic ent_t model(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [4:0]   rd,
    input logic         rw
  );
    longint unsigned m;
    longint          sa;
    longint          sb;
    logic [W-1:0]    r;
    logic            ill;
    m   = 64'd1 << W;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ill = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = a ^ b;
      4'b0111: r = (sa < sb) ? W'(1) : W'(0);
      4'b0010: r = W'((64'(a) + 64'(b)) % m);
      4'b0110: r = W'((64'(a) + m - 64'(b)) % m);
      default: begin
        r   = '0;
        ill = 1'b1;
      end
    endcase
    return {r, r == '0, rd, rw & ~ill, ill};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] rd,
                       input logic rw);
    in_valid     = 1'b1;
    in_operation = op;
    in_a         = a;
    in_b         = b;
    in_rd        = rd;
    in_regwrite  = rw;
  endtask

  // Record accepted ops; a flush discards everything in flight.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (flush)
        exp_q.delete();
      else if (in_valid && in_ready)
        exp_q.push_back(model(in_operation, in_a, in_b, in_rd, in_regwrite));
      hold_inputs = in_valid && !in_ready && !flush;
    end else begin
      hold_inputs = 1'b0;
    end
  end

  ent_t prev_out;
  logic prev_stall = 1'b0;
  logic prev_flush = 1'b0;

  // Monitor: compare every output transfer and stall stability.
  always @(negedge clk) begin
    ent_t cur;
    ent_t e;
    cur = {out_result, out_zero, out_rd, out_regwrite, out_illegal};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_flush) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'(cur), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra: got %0h expected no output", cur);
        end else begin
          e = exp_q.pop_front();
          chk("sb_entry", 64'(cur), 64'(e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      prev_flush = flush;
    end
  end

  logic [3:0] legal_ops [6];
  logic [W-1:0] corner [4];

  initial begin
    legal_ops = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0010, 4'b0110};
    corner    = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    #2;
    chk("rst_outs", 64'({out_valid, out_result, out_zero, out_rd,
                          out_regwrite, out_illegal}), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    drive(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1);
    step();
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_result", 64'(out_result), 64'd0);
    chk("add_zero", 64'(out_zero), 64'd1);

    drive(4'b0110, 32'd5, 32'd7, 5'd4, 1'b1);
    step();
    chk("sub_result", 64'(out_result), 64'hFFFF_FFFE);
    chk("sub_ready", 64'(in_ready), 64'd1);
    drive(4'b0111, 32'hFFFF_FFFE, 32'd1, 5'd5, 1'b1);
    step();
    chk("slt_result", 64'(out_result), 64'd1);
    chk("slt_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    step();

    out_ready = 1'b0;
    drive(4'b0000, 32'hF0F0, 32'h0FF0, 5'd6, 1'b1);
    step();
    chk("and_main", 64'(out_result), 64'h00F0);
    chk("and_ready", 64'(in_ready), 64'd1);
    drive(4'b0001, 32'h1, 32'h2, 5'd7, 1'b1);
    step();
    in_valid = 1'b0;
    chk("skid_ready", 64'(in_ready), 64'd0);
    chk("skid_main", 64'(out_result), 64'h00F0);
    step();
    chk("stall_main", 64'(out_result), 64'h00F0);
    out_ready = 1'b1;
    step();
    chk("drain_result", 64'(out_result), 64'h3);
    chk("drain_valid", 64'(out_valid), 64'd1);
    chk("drain_ready", 64'(in_ready), 64'd1);
    step();
    chk("drain_empty", 64'(out_valid), 64'd0);

    drive(4'b1111, 32'd3, 32'd4, 5'd9, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ill_flag", 64'(out_illegal), 64'd1);
    chk("ill_result", 64'(out_result), 64'd0);
    chk("ill_zero", 64'(out_zero), 64'd1);
    chk("ill_regwrite", 64'(out_regwrite), 64'd0);
    step();

    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd10, 1'b1);
    step();
    drive(4'b0001, 32'h55, 32'hAA, 5'd11, 1'b1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush1_valid", 64'(out_valid), 64'd0);
    chk("flush1_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    chk("flush1_gone", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    drive(4'b0010, 32'd8, 32'd9, 5'd12, 1'b1);
    step();
    drive(4'b0110, 32'd9, 32'd8, 5'd13, 1'b1);
    step();
    chk("full_ready", 64'(in_ready), 64'd0);
    drive(4'b1100, 32'h33, 32'h11, 5'd14, 1'b1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2_valid", 64'(out_valid), 64'd0);
    chk("flush2_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    step();
    chk("flush2_gone", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    drive(4'b0000, 32'hFF, 32'hFF, 5'd15, 1'b1);
    step();
    drive(4'b0001, 32'h1, 32'h6, 5'd16, 1'b1);
    step();
    in_valid = 1'b0;
    chk("arst_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_outs", 64'({out_valid, out_result, out_zero, out_rd,
                           out_regwrite, out_illegal}), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    drive(4'b1100, 32'hA, 32'h5, 5'd17, 1'b1);
    step();
    in_valid = 1'b0;
    chk("xor_valid", 64'(out_valid), 64'd1);
    chk("xor_result", 64'(out_result), 64'hF);

    for (int i = 0; i < 600; i++) begin
      if (!hold_inputs) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0)
          in_operation = 4'($urandom);
        else
          in_operation = legal_ops[$urandom_range(0, 5)];
        in_a = ($urandom_range(0, 3) == 0) ?
               corner[$urandom_range(0, 3)] : W'($urandom);
        in_b = ($urandom_range(0, 3) == 0) ?
               corner[$urandom_range(0, 3)] : W'($urandom);
        in_rd       = 5'($urandom);
        in_regwrite = 1'($urandom);
      end
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("final_queue", 64'(exp_q.size()), 64'd0);
    chk("final_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
